// File: rtl/tick_generator.sv
// rtl/tick_generator.sv - programmable one-cycle pulse every N enabled clocks; TICK_GEN_TICK_COUNT_EN adds tick_count
module tick_generator #(
    parameter int WIDTH                   = 28,
    parameter int unsigned DEFAULT_PERIOD = 50000000,
    parameter int COUNT_WIDTH             = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   load,
    input  logic [WIDTH-1:0]       period,
    output logic                   out_pulse,
    output logic [WIDTH-1:0]       remaining
`ifdef TICK_GEN_TICK_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] tick_count
`endif
);

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DEF_PER  = DEFAULT_PERIOD[WIDTH-1:0];

    logic [WIDTH-1:0] period_reg;
    logic [WIDTH-1:0] peff;
    logic             wrap;

    // A zero period would never fire; treat it as the fastest legal rate.
    assign peff = (period == '0) ? ONE : period;
    assign wrap = enable && (remaining == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            period_reg <= DEF_PER;
            remaining  <= DEF_PER - ONE;
            out_pulse  <= 1'b0;
        end else if (load) begin
            period_reg <= peff;
            remaining  <= peff - ONE;
            out_pulse  <= 1'b0;
        end else if (wrap) begin
            remaining  <= period_reg - ONE;
            out_pulse  <= 1'b1;
        end else if (enable) begin
            remaining  <= remaining - ONE;
            out_pulse  <= 1'b0;
        end else begin
            out_pulse  <= 1'b0;
        end
    end

`ifdef TICK_GEN_TICK_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset || load) begin
            tick_count <= '0;
        end else if (wrap) begin
            tick_count <= tick_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tick_generator.sv
// tb/tb_tick_generator.sv - self-checking bench for tick_generator
module tb_tick_generator;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic [7:0] period = 8'd0;
    logic       out_pulse;
    logic [7:0] remaining;
`ifdef TICK_GEN_TICK_COUNT_EN
    logic [3:0] tick_count;
`endif

    int tests = 0;
    int failed = 0;

    // reference: period in force and enabled edges since the last reset/load
    int   m_p = 4;
    int   m_e = 0;
    logic m_pulse = 1'b0;

    tick_generator #(
        .WIDTH(8),
        .DEFAULT_PERIOD(4),
        .COUNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .load(load),
        .period(period),
        .out_pulse(out_pulse),
        .remaining(remaining)
`ifdef TICK_GEN_TICK_COUNT_EN
        ,
        .tick_count(tick_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       en;
        logic       ld;
        logic [7:0] p;
        logic       ep;
        logic [7:0] er;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic en, input logic ld, input logic [7:0] p);
        reset  = r;
        enable = en;
        load   = ld;
        period = p;
        @(posedge clk);
        if (r) begin
            m_p = 4; m_e = 0; m_pulse = 1'b0;
        end else if (ld) begin
            m_p = (p == 8'd0) ? 1 : int'(p); m_e = 0; m_pulse = 1'b0;
        end else if (en) begin
            m_e++;
            m_pulse = ((m_e % m_p) == 0);
        end else begin
            m_pulse = 1'b0;
        end
        #1;
        check("model_pulse", int'(out_pulse), int'(m_pulse));
        check("model_remaining", int'(remaining), m_p - 1 - (m_e % m_p));
`ifdef TICK_GEN_TICK_COUNT_EN
        check("model_tick_count", int'(tick_count), (m_e / m_p) % 16);
`endif
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd3};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd2};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 8'd3};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd2};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 8'd3};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd2};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 8'd3};

        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].r, vecs[i].en, vecs[i].ld, vecs[i].p);
            check("vec_pulse", int'(out_pulse), int'(vecs[i].ep));
            check("vec_remaining", int'(remaining), int'(vecs[i].er));
        end

        // pause holds the position; the pulse comes after two more enabled edges
        cycle(1'b1, 1'b0, 1'b0, 8'd0);
        cycle(1'b0, 1'b1, 1'b0, 8'd0);
        cycle(1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 8'd0);
            check("pause_remaining", int'(remaining), 1);
            check("pause_pulse", int'(out_pulse), 0);
        end
        cycle(1'b0, 1'b1, 1'b0, 8'd0);
        check("resume_first_pulse", int'(out_pulse), 0);
        cycle(1'b0, 1'b1, 1'b0, 8'd0);
        check("resume_pulse", int'(out_pulse), 1);
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        check("pulse_drops_after_disable", int'(out_pulse), 0);

        // load mid-count
        cycle(1'b1, 1'b0, 1'b0, 8'd0);
        cycle(1'b0, 1'b1, 1'b0, 8'd0);
        cycle(1'b0, 1'b1, 1'b1, 8'd6);
        check("load_remaining", int'(remaining), 5);
        check("load_pulse", int'(out_pulse), 0);
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'd0);
            check("load_period_pulse", int'(out_pulse), (i == 6) ? 1 : 0);
        end

        // degenerate periods 0 and 1
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'(k));
            for (int i = 0; i < 5; i++) begin
                cycle(1'b0, 1'b1, 1'b0, 8'd0);
                check("degen_pulse", int'(out_pulse), 1);
                check("degen_remaining", int'(remaining), 0);
            end
        end

        // load coinciding with a due pulse, then reset with load and enable
        cycle(1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'd0);
        check("due_remaining", int'(remaining), 0);
        cycle(1'b0, 1'b1, 1'b1, 8'd5);
        check("load_due_pulse", int'(out_pulse), 0);
        check("load_due_remaining", int'(remaining), 4);
        cycle(1'b0, 1'b1, 1'b0, 8'd0);
        cycle(1'b1, 1'b1, 1'b1, 8'd9);
        check("reset_all_pulse", int'(out_pulse), 0);
        check("reset_all_remaining", int'(remaining), 3);
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'd0);
            check("reset_period_pulse", int'(out_pulse), (i == 4) ? 1 : 0);
        end

`ifdef TICK_GEN_TICK_COUNT_EN
        cycle(1'b0, 1'b0, 1'b1, 8'd2);
        for (int i = 0; i < 34; i++) cycle(1'b0, 1'b1, 1'b0, 8'd0);
        check("tick_count_wrap", int'(tick_count), 1);
        cycle(1'b0, 1'b1, 1'b1, 8'd2);
        check("tick_count_load_clear", int'(tick_count), 0);
`endif

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 29) == 0), 8'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/tick_generator.md
# tick_generator

Programmable pulse source that emits a single-cycle `out_pulse` once every N clock cycles while enabled. It is the producer end of the pulse interface consumed by the team's pulse-driven counters (e.g. the 5..0 down counter), turning the 50 MHz board clock into game-rate ticks such as 1 Hz seconds. Period is set by parameter at reset and can be reloaded at run time; the countdown can be paused without losing its position.

## Interface
- `WIDTH`, 28, width of the period and remaining-count registers.
- `DEFAULT_PERIOD`, 50000000, period loaded at reset; must be ≥1 and < 2^WIDTH.
- `COUNT_WIDTH`, 4, width of `tick_count` (only when `TICK_GEN_TICK_COUNT_EN` is defined).

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock, rising-edge.
- `reset` input 1: synchronous, active-high; highest priority.
- `enable` input 1: count down while high; hold while low.
- `load` input 1: one-cycle strobe; capture `period` and restart the countdown.
- `period` input WIDTH: new period, sampled only when `load` is high.
- `out_pulse` output 1: registered, high for exactly one cycle per elapsed period.
- `remaining` output WIDTH: current countdown value, registered.
- `tick_count` output COUNT_WIDTH: pulses emitted since reset/load (macro only).

## Operation
- Internal state: `period_reg` (WIDTH), `remaining` (WIDTH), `out_pulse` (1).
- Effective period `Peff` = `period` if `period` ≥ 1, else 1. A value of 0 is never stored.
- Priority per rising edge: reset > load > enable > hold.
- Reset: `period_reg`=DEFAULT_PERIOD, `remaining`=DEFAULT_PERIOD-1, `out_pulse`=0, `tick_count`=0.
- Load: `period_reg`=Peff, `remaining`=Peff-1, `out_pulse`=0, `tick_count`=0. `enable` is ignored that cycle.
- Enable, `remaining`≠0: `remaining` decrements by 1; `out_pulse`=0.
- Enable, `remaining`=0: `out_pulse`=1; `remaining` reloads to `period_reg`-1; `tick_count` increments.
- Enable low: `remaining` and `tick_count` hold; `out_pulse`=0. A pulse due while paused is not emitted; it fires when counting resumes.
- Arithmetic is unsigned WIDTH-bit. `remaining` never underflows because reload happens at 0.

## Timing
- After reset or load, with `enable` held high, the first `out_pulse` is high in the cycle following the Peff-th enabled edge. Subsequent pulses are exactly Peff enabled cycles apart.
- Peff=1: `remaining` stays 0 and `out_pulse` is high every cycle while `enable` is high.
- `out_pulse` width is always exactly one cycle unless Peff=1 with continuous enable.
- Load mid-count discards the old countdown immediately, with no pulse for the partial period. If `load` coincides with a due pulse, the pulse is suppressed.
- Reset mid-operation: all outputs take their reset values on the next edge, regardless of `load` or `enable`.
- The `enable` deassert edge does not cancel a pulse already registered. `out_pulse` drops on the next edge.
- No combinational paths from inputs to outputs.

## Configuration
- `TICK_GEN_TICK_COUNT_EN` defined: `tick_count` port and register exist. It increments on each emitted pulse, wraps from 2^COUNT_WIDTH-1 to 0, and is cleared by reset and load.
- Not defined: `tick_count` port and logic are absent. All other behaviour is identical.

## Test plan
- Reset with DEFAULT_PERIOD=4: after reset, `remaining`=3 and `out_pulse`=0. With enable high, `out_pulse` is high on the cycles after edges 4, 8 and 12, and low otherwise; `remaining` follows 2,1,0,3,2,...
- Pause: with DEFAULT_PERIOD=4, enable for 2 cycles (`remaining`=1), drop enable for 5 cycles (`remaining` stays 1, no pulse), then re-enable. The pulse appears after 2 further enabled edges.
- Load mid-count: at `remaining`=2, load `period`=6. The next cycle shows `remaining`=5 and `out_pulse`=0; the next pulse follows exactly 6 enabled edges later.
- Degenerate period: load `period`=0, then enable for 5 cycles. `out_pulse` is high all 5 cycles and `remaining` stays 0; loading `period`=1 gives the same result.
- Simultaneous events: load coinciding with `remaining`=0 gives no pulse and a restart. Reset asserted together with load and enable gives exact reset values.
- Macro on, COUNT_WIDTH=4, period 2: after 17 pulses `tick_count`=1. A load clears it to 0.
